muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Sequences the multi-cycle HI/LO unit for MULT/MULTU/DIV/DIVU in the E stage.
//  Latches operands and runs a latency-counted multiply or a 32-iteration radix-2 restoring divide.
//  Stalls the pipeline front-end while busy and pulses hilo_we exactly once per completed op.
//  Sits beside the E-stage ALU; the HI/LO register file consumes hi_out/lo_out/hilo_we.
// PARAMETERS
//  MUL_LAT   2   multiply compute cycles after the accept cycle (>=1)
//  WIDTH     32  operand width; HI/LO each WIDTH bits
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  op_valid  in   1      E-stage instruction is a mul/div (from decoder hilo_write path)
//  op_code   in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src_a     in   WIDTH  rs operand (dividend / multiplicand)
//  src_b     in   WIDTH  rt operand (divisor / multiplier)
//  flush     in   1      exception/ERET kills the E-stage instruction
//  hold_e    in   1      E stage frozen by a downstream stall
//  stall_md  out  1      freeze F/D/E: mul/div in progress
//  busy      out  1      state != IDLE
//  hilo_we   out  1      one-cycle write strobe for HI/LO
//  hi_out    out  WIDTH  HI result (product high / remainder)
//  lo_out    out  WIDTH  LO result (product low / quotient)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, hi_out=lo_out=0, hilo_we=0, busy=0; stall_md follows its equation (IDLE).
//  States: IDLE, MUL, DIV, DONE.
//  stall_md = op_valid & ~flush & (state != DONE)   (combinational)
//  hilo_we  = (state == DONE) & ~hold_e & ~flush    (combinational)
//  IDLE: op_valid & ~flush -> latch |a|,|b| (signed ops) or raw (unsigned) plus sign flags;
//        op_code[1]=0 -> MUL, cnt=MUL_LAT-1; op_code[1]=1 -> DIV, cnt=WIDTH-1.
//  MUL: cnt decrements; at cnt==0 load 2*WIDTH product (sign-corrected) into hi/lo -> DONE.
//  DIV: one restoring step per cycle (shift rem:quo left, trial-subtract divisor, set quo bit);
//       at cnt==0 apply sign fix (quotient negated if signs differ; remainder takes dividend sign),
//       load hi_out=rem, lo_out=quo -> DONE.
//  DONE: ~hold_e -> IDLE (hilo_we high this cycle); hold_e -> stay DONE, hilo_we low, results held.
//  Stall cycles: MUL = 1+MUL_LAT; DIV = 1+WIDTH (=33); DONE cycle never stalls.
//  Operand inputs are ignored after the accept cycle; hi_out/lo_out change only on entry to DONE.
//  Divide by zero: no exception; result is what the algorithm yields
//    (DIVU x/0 -> LO=all-ones, HI=x; DIV applies the same sign fix).
//  flush (any state): highest priority; next state IDLE, no hilo_we, stall_md low in that cycle;
//    hi_out/lo_out keep previous values; a new op may be accepted the cycle after.
//  op_valid deasserting mid-operation (without flush) does not abort; op completes to DONE.
//  Reset mid-operation: immediate return to reset values, no hilo_we.
// TESTING
//  MULT a=-3 b=5, MUL_LAT=2 -> stall_md high 3 cycles, then hilo_we 1 cycle, HI=FFFFFFFF LO=FFFFFFF1.
//  DIV a=-7 b=2 -> stall_md high 33 cycles, then HI=FFFFFFFF (-1), LO=FFFFFFFD (-3), one hilo_we.
//  DIVU a=00000010 b=0 -> LO=FFFFFFFF, HI=00000010; MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE LO=00000001.
//  DIV, flush at 10th busy cycle -> IDLE next edge, no hilo_we, hi/lo unchanged; MULT accepted next cycle.
//  hold_e high for 3 cycles on reaching DONE -> stall_md low, hilo_we low, then exactly one pulse on release.
//  rst asserted mid-DIV -> busy/hilo_we/hi_out/lo_out = 0 immediately; new DIVU after release correct.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequencer for the E-stage HI/LO unit: latency-counted multiply and radix-2 restoring divide.
// Holds the front-end stalled while an op is in flight and strobes hilo_we once per completed op.
module muldiv_seq #(
  parameter int MUL_LAT = 2,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hold_e,
  output logic             stall_md,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH - 1 : MUL_LAT - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   hi_acc;
  logic [WIDTH-1:0]   lo_acc;
  logic [WIDTH-1:0]   opb;
  logic               neg_q;
  logic               neg_r;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic               accept;

  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign a_s       = src_a;
  assign b_s       = src_b;
  assign is_signed = ~op_code[0];
  assign a_neg     = is_signed & (a_s < 0);
  assign b_neg     = is_signed & (b_s < 0);
  assign accept    = (state == IDLE) & op_valid & ~flush;

  assign stall_md  = op_valid & ~flush & (state != DONE);
  assign hilo_we   = (state == DONE) & ~hold_e & ~flush;
  assign busy      = (state != IDLE);

  // One restoring step: shift rem:quo left, keep the trial difference when it does not underflow.
  always_comb begin
    shifted  = {hi_acc, lo_acc[WIDTH-1]};
    fits     = (shifted >= {1'b0, opb});
    step_rem = fits ? (shifted[WIDTH-1:0] - opb) : shifted[WIDTH-1:0];
    step_quo = {lo_acc[WIDTH-2:0], fits};
  end

  assign prod = {{WIDTH{1'b0}}, lo_acc} * {{WIDTH{1'b0}}, opb};

  // Operand / partial-result registers: magnitudes plus sign flags captured at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_acc <= neg_if(src_a, a_neg);
      opb    <= neg_if(src_b, b_neg);
      hi_acc <= '0;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
    end else if (state == DIV) begin
      hi_acc <= step_rem;
      lo_acc <= step_quo;
    end
  end

  // Control FSM; flush overrides every state and leaves HI/LO untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else if (flush) begin
      state  <= IDLE;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (op_code[1]) begin
              state <= DIV;
              cnt   <= CNT_W'(WIDTH - 1);
            end else begin
              state <= MUL;
              cnt   <= CNT_W'(MUL_LAT - 1);
            end
          end
        end
        MUL: begin
          if (cnt == '0) begin
            {hi_out, lo_out} <= neg_if_wide(prod, neg_q);
            state            <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DIV: begin
          if (cnt == '0) begin
            hi_out <= neg_if(step_rem, neg_r);
            lo_out <= neg_if(step_quo, neg_q);
            state  <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (!hold_e) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with hand-computed results (MUL_LAT=2, WIDTH=32).
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        hold_e;
  logic        stall_md;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int tests = 0;
  int fails = 0;

  muldiv_seq #(.MUL_LAT(2), .WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .hold_e   (hold_e),
    .stall_md (stall_md),
    .busy     (busy),
    .hilo_we  (hilo_we),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one op and measures it; returns at the cycle after the hilo_we pulse.
  task automatic run_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                        input bit chain, output int stalls, output int wes,
                        output logic [31:0] hi, output logic [31:0] lo);
    stalls = 0; wes = 0; hi = '0; lo = '0;
    op_valid = 1'b1; op_code = code; src_a = a; src_b = b;
    for (int i = 0; i < 60 && wes == 0; i++) begin
      @(negedge clk);
      if (stall_md) stalls++;
      if (hilo_we) begin wes++; hi = hi_out; lo = lo_out; end
      @(posedge clk); #1;
      src_a = ~a; src_b = a ^ b ^ 32'h5A5A_0F0F;
    end
    if (!chain) begin
      op_valid = 1'b0;
      @(negedge clk);
      if (hilo_we) wes++;
      if (stall_md) stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op_code = 2'b00; src_a = '0; src_b = '0;
    flush = 1'b0; hold_e = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (hilo_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", hilo_we); end
    tests++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
      fails++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi_out, lo_out); end
    tests++; if (stall_md !== 1'b0) begin fails++; $display("FAIL reset_stall_idle: got %b want 0", stall_md); end
    op_valid = 1'b1; #1;
    tests++; if (stall_md !== 1'b1) begin fails++; $display("FAIL reset_stall_eq: got %b want 1", stall_md); end
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    logic [1:0]  c  [5] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [31:0] ta [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00000007, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] tb [5] = '{32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] eh [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'h00000000};
    logic [31:0] el [5] = '{32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFD6, 32'h00000000, 32'h00000001};
    int st, we; logic [31:0] h, l;
    for (int k = 0; k < 5; k++) begin
      run_op(c[k], ta[k], tb[k], 1'b0, st, we, h, l);
      tests++; if (st != 3) begin fails++; $display("FAIL mul%0d_stalls: got %0d want 3", k, st); end
      tests++; if (we != 1) begin fails++; $display("FAIL mul%0d_we: got %0d want 1", k, we); end
      tests++; if (h !== eh[k] || l !== el[k]) begin
        fails++; $display("FAIL mul%0d_result: got %h/%h want %h/%h", k, h, l, eh[k], el[k]); end
    end
  endtask

  task automatic test_div();
    logic [1:0]  c  [6] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
    logic [31:0] ta [6] = '{32'hFFFFFFF9, 32'h00000007, 32'h00000064, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] tb [6] = '{32'h00000002, 32'hFFFFFFFE, 32'h00000007, 32'h00000001, 32'hFFFFFFFF, 32'h00000002};
    logic [31:0] eh [6] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000002, 32'h00000000, 32'h00000000, 32'h00000001};
    logic [31:0] el [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0000000E, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFC};
    int st, we; logic [31:0] h, l;
    for (int k = 0; k < 6; k++) begin
      run_op(c[k], ta[k], tb[k], 1'b0, st, we, h, l);
      tests++; if (st != 33) begin fails++; $display("FAIL div%0d_stalls: got %0d want 33", k, st); end
      tests++; if (we != 1) begin fails++; $display("FAIL div%0d_we: got %0d want 1", k, we); end
      tests++; if (h !== eh[k] || l !== el[k]) begin
        fails++; $display("FAIL div%0d_result: got %h/%h want %h/%h", k, h, l, eh[k], el[k]); end
    end
  endtask

  task automatic test_div_zero();
    int st, we; logic [31:0] h, l;
    run_op(2'b10, 32'hFFFFFFFA, 32'h0, 1'b0, st, we, h, l);
    tests++; if (we != 1 || h !== 32'hFFFFFFFA || l !== 32'h00000001) begin
      fails++; $display("FAIL div_by_zero_signed: got we=%0d %h/%h want 1 FFFFFFFA/00000001", we, h, l); end
    run_op(2'b11, 32'h00000010, 32'h0, 1'b0, st, we, h, l);
    tests++; if (we != 1 || h !== 32'h00000010 || l !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL divu_by_zero: got we=%0d %h/%h want 1 00000010/FFFFFFFF", we, h, l); end
  endtask

  task automatic test_flush();
    int nbusy, we_seen, st, we; logic [31:0] h, l;
    nbusy = 0; we_seen = 0;
    op_valid = 1'b1; op_code = 2'b10; src_a = 32'd100; src_b = 32'd7;
    for (int i = 0; i < 40 && nbusy < 10; i++) begin
      @(negedge clk);
      if (hilo_we) we_seen++;
      if (busy) nbusy++;
      if (nbusy < 10) begin @(posedge clk); #1; end
    end
    flush = 1'b1; #1;
    tests++; if (stall_md !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b want 0", stall_md); end
    tests++; if (hilo_we !== 1'b0 || we_seen != 0) begin
      fails++; $display("FAIL flush_we: got %b (earlier %0d) want 0", hilo_we, we_seen); end
    @(posedge clk); #1;
    flush = 1'b0; op_code = 2'b00; src_a = 32'd4; src_b = 32'd5; #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_idle: busy got %b want 0", busy); end
    tests++; if (hi_out !== 32'h00000010 || lo_out !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL flush_hilo_kept: got %h/%h want 00000010/FFFFFFFF", hi_out, lo_out); end
    run_op(2'b00, 32'd4, 32'd5, 1'b0, st, we, h, l);
    tests++; if (st != 3 || we != 1 || h !== 32'h0 || l !== 32'd20) begin
      fails++; $display("FAIL flush_next_mult: got st=%0d we=%0d %h/%h want 3 1 0/14", st, we, h, l); end
  endtask

  task automatic test_hold();
    int bad;
    op_valid = 1'b1; op_code = 2'b00; src_a = 32'd3; src_b = 32'd3; hold_e = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if (stall_md !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL hold_pre_stall: got %0d bad cycles want 0", bad); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (stall_md !== 1'b0 || hilo_we !== 1'b0 || busy !== 1'b1 || lo_out !== 32'd9) bad++;
      @(posedge clk); #1;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL hold_done: got %0d bad cycles want 0", bad); end
    hold_e = 1'b0;
    @(negedge clk);
    tests++; if (hilo_we !== 1'b1) begin fails++; $display("FAIL hold_release_we: got %b want 1", hilo_we); end
    tests++; if (hi_out !== 32'h0 || lo_out !== 32'd9) begin
      fails++; $display("FAIL hold_result: got %h/%h want 0/9", hi_out, lo_out); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    tests++; if (hilo_we !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL hold_after: got we=%b busy=%b want 0/0", hilo_we, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int st, we; logic [31:0] h, l;
    op_valid = 1'b1; op_code = 2'b10; src_a = 32'd100; src_b = 32'd7;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1; #1;
    tests++; if (busy !== 1'b0 || hilo_we !== 1'b0) begin
      fails++; $display("FAIL rst_mid_ctrl: got busy=%b we=%b want 0/0", busy, hilo_we); end
    tests++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
      fails++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", hi_out, lo_out); end
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(2'b11, 32'd100, 32'd7, 1'b0, st, we, h, l);
    tests++; if (st != 33 || we != 1 || h !== 32'd2 || l !== 32'd14) begin
      fails++; $display("FAIL rst_mid_next_divu: got st=%0d we=%0d %h/%h want 33 1 2/E", st, we, h, l); end
  endtask

  task automatic test_back_to_back();
    int st, we; logic [31:0] h, l;
    run_op(2'b01, 32'h00010000, 32'h00010000, 1'b1, st, we, h, l);
    tests++; if (st != 3 || we != 1 || h !== 32'h1 || l !== 32'h0) begin
      fails++; $display("FAIL b2b_multu: got st=%0d we=%0d %h/%h want 3 1 1/0", st, we, h, l); end
    run_op(2'b10, 32'd100, 32'hFFFFFFF9, 1'b0, st, we, h, l);
    tests++; if (st != 33 || we != 1 || h !== 32'd2 || l !== 32'hFFFFFFF2) begin
      fails++; $display("FAIL b2b_div: got st=%0d we=%0d %h/%h want 33 1 2/FFFFFFF2", st, we, h, l); end
  endtask

  task automatic test_valid_drop();
    int we; logic [31:0] h, l;
    we = 0; h = '0; l = '0;
    op_valid = 1'b1; op_code = 2'b11; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0; src_a = '0; src_b = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hilo_we) begin we++; h = hi_out; l = lo_out; end
      @(posedge clk); #1;
    end
    tests++; if (we != 1) begin fails++; $display("FAIL valid_drop_we: got %0d want 1", we); end
    tests++; if (h !== 32'd1 || l !== 32'd333) begin
      fails++; $display("FAIL valid_drop_result: got %h/%h want 1/14D", h, l); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_valid_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
